fft_reorder: RTL and testbench
==============================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 The block SHALL have parameter DW, default 15: signed sample width of real and imaginary parts (6-bit integer, 8-bit fractional plus growth bit); frame length is fixed at 32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, with all state updating on the rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush, input, 1 bit: synchronous abort that discards all buffered data.
REQ-005 The block SHALL have port in_valid, input, 1 bit: an FFT output sample is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a sample this cycle.
REQ-007 The block SHALL have ports in_r and in_i, input, DW bits signed each: the sample, arriving in bit-reversed order.
REQ-008 The block SHALL have port out_valid, output, 1 bit: out_r, out_i and out_idx are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the sample.
REQ-010 The block SHALL have ports out_r and out_i, output, DW bits signed each: the sample in natural order.
REQ-011 The block SHALL have port out_idx, output, 5 bits: natural-order frequency index k of the current output.
REQ-012 The block SHALL have port out_last, output, 1 bit: asserted together with out_idx=31 while out_valid is high.

Function
REQ-013 The block SHALL contain a ping-pong store of two banks, each holding 32 entries of {in_r, in_i}.
REQ-014 Each bank SHALL be in one of the states EMPTY, FILL, FULL or DRAIN.
- EMPTY -> FILL on the first write to the bank.
- FILL -> FULL on the edge that accepts write count 31.
- FULL -> DRAIN on the first output transfer from the bank.
- DRAIN -> EMPTY on the edge that transfers out_idx=31.
- A single-sample frame path SHALL be handled directly: FULL -> EMPTY if the bank is fully read without an intermediate cycle (not reachable with 32 samples; it is listed for completeness).
REQ-015 An input transfer SHALL occur iff in_valid && in_ready.
- The n-th accepted sample of a frame (n = 0..31, held in wr_cnt) SHALL be written to address bitrev5(n) of bank wr_bank.
- Example: n=1 is written to address 16, and n=3 to address 24.
REQ-016 On acceptance of n=31, wr_cnt SHALL wrap to 0 and wr_bank SHALL toggle on the same edge.
REQ-017 in_ready SHALL equal (state[wr_bank] is EMPTY or FILL) && !flush, and it SHALL be registered-state based with no combinational path from out_ready.
REQ-018 out_valid SHALL equal (state[rd_bank] is FULL or DRAIN) && !flush.
- out_r and out_i SHALL be driven combinationally from entry rd_idx of bank rd_bank.
- out_idx SHALL equal rd_idx.
REQ-019 An output transfer SHALL occur iff out_valid && out_ready; rd_idx SHALL then increment, and on rd_idx=31 it SHALL wrap to 0 and rd_bank SHALL toggle.
REQ-020 While out_valid=1 && out_ready=0, out_r, out_i, out_idx and out_last SHALL remain stable.
REQ-021 Latency: the first out_valid of a frame SHALL assert in the cycle immediately following the edge that accepted input n=31, provided the read bank was otherwise idle.
REQ-022 Throughput: with in_valid=1 and out_ready=1 held continuously, the block SHALL sustain one sample per cycle in and out with no bubbles after the first frame.
REQ-023 Boundary conditions:
- Both banks non-EMPTY and not FILL: in_ready SHALL be 0.
- A bank draining to EMPTY SHALL make in_ready=1 no earlier than the next cycle.
- No same-cycle write into a bank being read is permitted.
REQ-024 Simultaneous input and output transfers in the same cycle SHALL update both pointers independently.
REQ-025 Data SHALL pass through unmodified: no rounding, scaling or saturation.
REQ-026 flush=1 SHALL, at the next edge:
- set both banks to EMPTY;
- set wr_cnt, rd_idx, wr_bank and rd_bank to 0;
- discard any transfer attempted in that cycle.
REQ-027 A partially written frame SHALL never be output.

Reset
REQ-028 While rst_n=0, the block SHALL hold both banks EMPTY and set wr_cnt=0, rd_idx=0, wr_bank=0 and rd_bank=0.
REQ-029 While rst_n=0, the outputs SHALL be out_valid=0, out_last=0, out_idx=0 and in_ready=0.
REQ-030 Buffer contents SHALL NOT be required to reset, and out_r and out_i SHALL be don't-care while out_valid=0.
REQ-031 in_ready SHALL rise in the first cycle after rst_n deasserts.
REQ-032 Reset asserted mid-frame or mid-drain SHALL abort all activity immediately, with no output transfer afterward until a new complete frame has been received.

Verification
REQ-033 Single frame: feed in_r = bitrev5(n)*256 and in_i = -n for n = 0..31 with out_ready=1.
- Expected: out_valid rises 1 cycle after n=31 is accepted.
- Expected: out_r = k*256 and out_idx = k for k = 0..31 in order.
- Expected: out_last is high only at k=31.
REQ-034 Back-to-back: stream 4 frames continuously with out_ready=1.
- Expected: in_ready stays 1 throughout.
- Expected: 128 outputs with no gaps after the first out_valid, and every frame is correctly reordered.
REQ-035 Backpressure: hold out_ready=0 while sending 2 frames.
- Expected: in_ready drops to 0 after 64 accepts.
- Expected: outputs stay stable at k=0 of frame 0.
- After releasing out_ready: frame 0, then frame 1, drain in order, and in_ready returns to 1 one cycle after frame 0's k=31 transfer.
REQ-036 Random stall: randomize in_valid and out_ready at 50% over 20 frames.
- Expected: a scoreboard matches every natural-order sample.
- Expected: no output occurs while the matching input frame is incomplete.
REQ-037 Flush: assert flush after 10 accepts of frame 1 while frame 0 is draining at k=5.
- Expected: next cycle out_valid=0 and in_ready=1.
- Expected: a fresh frame is then reordered correctly starting at bank 0.
REQ-038 Reset: drop rst_n asynchronously mid-drain at k=17.
- Expected: out_valid=0, out_idx=0 and in_ready=0 immediately.
- Expected: after release, in_ready=1 next cycle and a new frame outputs from k=0.

Source files
------------

// File: rtl/fft_reorder.sv
// Bit-reversed to natural-order reorder buffer for a 32-point FFT.
// Two 32-entry banks ping-pong: one bank fills while the other drains.
module fft_reorder #(
    parameter int DW = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_r,
    input  logic signed [DW-1:0] in_i,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [DW-1:0] out_r,
    output logic signed [DW-1:0] out_i,
    output logic [4:0]           out_idx,
    output logic                 out_last
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_FILL  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    logic [4:0]      wr_cnt_q, wr_cnt_d;
    logic [4:0]      rd_idx_q, rd_idx_d;
    logic            wr_bank_q, wr_bank_d;
    logic            rd_bank_q, rd_bank_d;
    logic [3:0]      st_flat;
    logic [1:0]      st_wr, st_rd;
    logic            in_fire, out_fire;
    logic [4:0]      wr_addr;
    logic [2*DW-1:0] mem_q [64];
    logic [2*DW-1:0] rd_word;

    assign st_wr = wr_bank_q ? st_flat[3:2] : st_flat[1:0];
    assign st_rd = rd_bank_q ? st_flat[3:2] : st_flat[1:0];

    // rst_n gating keeps in_ready low while the block is held in reset.
    assign in_ready  = rst_n && !flush && ((st_wr == ST_EMPTY) || (st_wr == ST_FILL));
    assign out_valid = !flush && ((st_rd == ST_FULL) || (st_rd == ST_DRAIN));
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    for (genvar gi = 0; gi < 5; gi++) begin : g_bitrev
        assign wr_addr[gi] = wr_cnt_q[4-gi];
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic [1:0] st_q, st_d;
        logic       wr_here, rd_here;

        assign wr_here = in_fire && (wr_bank_q == 1'(gi));
        assign rd_here = out_fire && (rd_bank_q == 1'(gi));

        always_comb begin
            st_d = st_q;
            if (flush) begin
                st_d = ST_EMPTY;
            end else if (wr_here) begin
                st_d = (wr_cnt_q == 5'd31) ? ST_FULL : ST_FILL;
            end else if (rd_here) begin
                st_d = (rd_idx_q == 5'd31) ? ST_EMPTY : ST_DRAIN;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= ST_EMPTY;
            end else begin
                st_q <= st_d;
            end
        end

        assign st_flat[2*gi +: 2] = st_q;
    end

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_idx_d  = rd_idx_q;
        rd_bank_d = rd_bank_q;
        if (flush) begin
            wr_cnt_d  = 5'd0;
            wr_bank_d = 1'b0;
            rd_idx_d  = 5'd0;
            rd_bank_d = 1'b0;
        end else begin
            if (in_fire) begin
                wr_cnt_d = wr_cnt_q + 5'd1;
                if (wr_cnt_q == 5'd31) begin
                    wr_bank_d = ~wr_bank_q;
                end
            end
            if (out_fire) begin
                rd_idx_d = rd_idx_q + 5'd1;
                if (rd_idx_q == 5'd31) begin
                    rd_bank_d = ~rd_bank_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= 5'd0;
            wr_bank_q <= 1'b0;
            rd_idx_q  <= 5'd0;
            rd_bank_q <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_idx_q  <= rd_idx_d;
            rd_bank_q <= rd_bank_d;
        end
    end

    // Contents are not reset; outputs are only meaningful while out_valid is high.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_q[{wr_bank_q, wr_addr}] <= {in_r, in_i};
        end
    end

    assign rd_word  = mem_q[{rd_bank_q, rd_idx_q}];
    assign out_r    = rd_word[2*DW-1:DW];
    assign out_i    = rd_word[DW-1:0];
    assign out_idx  = rd_idx_q;
    assign out_last = out_valid && (rd_idx_q == 5'd31);

endmodule

// File: tb/tb_fft_reorder.sv
// Bench for fft_reorder: frame-level reference model plus directed corner sequences.
module tb_fft_reorder;
    localparam int DW = 15;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic signed [DW-1:0] in_r = '0;
    logic signed [DW-1:0] in_i = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic signed [DW-1:0] out_r;
    logic signed [DW-1:0] out_i;
    logic [4:0]           out_idx;
    logic                 out_last;

    fft_reorder #(.DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_i      (in_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_r     (out_r),
        .out_i     (out_i),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [DW-1:0] r;
        logic signed [DW-1:0] i;
        int                   k;
    } samp_t;

    typedef struct {
        logic signed [DW-1:0] in_r;
        logic signed [DW-1:0] in_i;
        int                   exp_k;
        logic signed [DW-1:0] exp_r;
        logic signed [DW-1:0] exp_i;
        logic                 exp_last;
    } vec_t;

    // Reference: samples of the current frame in arrival order, and the
    // natural-order samples of completed frames not yet delivered.
    samp_t                exp_q[$];
    logic signed [DW-1:0] arr_r[32];
    logic signed [DW-1:0] arr_i[32];
    int                   part_n = 0;
    int                   acc_cnt = 0;
    int                   out_cnt = 0;
    int                   n_pass = 0;
    int                   n_chk = 0;
    vec_t                 vec[32];

    function automatic int bitrev5(input int n);
        int r = 0;
        for (int b = 0; b < 5; b++) begin
            if (((n >> b) & 1) != 0) r += (1 << (4 - b));
        end
        return r;
    endfunction

    function automatic logic signed [DW-1:0] rnd();
        logic signed [DW-1:0] v;
        v = DW'($urandom);
        return v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, want, $time);
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, then
    // advance the model by the transfers that the coming edge performs.
    task automatic cycle(input logic iv, input logic signed [DW-1:0] ir,
                         input logic signed [DW-1:0] ii, input logic orr, input logic fl);
        logic  exp_rdy, exp_v, in_f, out_f;
        samp_t s;
        @(posedge clk);
        #1;
        in_valid  = iv;
        in_r      = ir;
        in_i      = ii;
        out_ready = orr;
        flush     = fl;
        #1;
        exp_rdy = !fl && (((exp_q.size() + 31) / 32) < 2);
        exp_v   = !fl && (exp_q.size() > 0);
        chk("in_ready", in_ready, exp_rdy);
        chk("out_valid", out_valid, exp_v);
        if (exp_v && out_valid) begin
            chk("out_idx", out_idx, exp_q[0].k);
            chk("out_r", out_r, exp_q[0].r);
            chk("out_i", out_i, exp_q[0].i);
            chk("out_last", out_last, exp_q[0].k == 31);
        end
        in_f  = iv && exp_rdy;
        out_f = exp_v && orr;
        if (fl) begin
            exp_q.delete();
            part_n = 0;
        end else begin
            if (out_f) begin
                $display("OUT k=%0d r=%0d i=%0d", exp_q[0].k, out_r, out_i);
                void'(exp_q.pop_front());
                out_cnt++;
            end
            if (in_f) begin
                arr_r[part_n] = ir;
                arr_i[part_n] = ii;
                part_n++;
                acc_cnt++;
                if (part_n == 32) begin
                    for (int k = 0; k < 32; k++) begin
                        s.r = arr_r[bitrev5(k)];
                        s.i = arr_i[bitrev5(k)];
                        s.k = k;
                        exp_q.push_back(s);
                    end
                    part_n = 0;
                end
            end
        end
    endtask

    task automatic drain_all(input int max);
        int c = 0;
        while (exp_q.size() > 0 && c < max) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            c++;
        end
        chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc0, c;
        logic iv;

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_release_in_ready", in_ready, 1);

        // Single frame against a fixed vector table
        for (int n = 0; n < 32; n++) begin
            vec[n].in_r = DW'(bitrev5(n) * 256);
            vec[n].in_i = DW'(-n);
        end
        for (int k = 0; k < 32; k++) begin
            vec[k].exp_k    = k;
            vec[k].exp_r    = DW'(k * 256);
            vec[k].exp_i    = DW'(-bitrev5(k));
            vec[k].exp_last = (k == 31);
        end
        for (int n = 0; n < 32; n++) cycle(1'b1, vec[n].in_r, vec[n].in_i, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            chk("sf_valid", out_valid, 1);
            chk("sf_idx", out_idx, vec[k].exp_k);
            chk("sf_r", out_r, vec[k].exp_r);
            chk("sf_i", out_i, vec[k].exp_i);
            chk("sf_last", out_last, vec[k].exp_last);
        end
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Back-to-back: four frames streamed continuously
        for (int n = 0; n < 128; n++) begin
            cycle(1'b1, rnd(), rnd(), 1'b1, 1'b0);
            chk("b2b_in_ready", in_ready, 1);
        end
        drain_all(100);

        // Backpressure: two frames with the consumer stalled
        for (int n = 0; n < 70; n++) cycle(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_idx", out_idx, 0);
        drain_all(100);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Random stalls over twenty frames
        acc0 = acc_cnt;
        c = 0;
        while (((acc_cnt - acc0) < 640 || exp_q.size() > 0) && c < 6000) begin
            iv = ((acc_cnt - acc0) < 640) && ($urandom_range(0, 1) == 1);
            cycle(iv, rnd(), rnd(), $urandom_range(0, 1) == 1, 1'b0);
            c++;
        end
        chk("rand_accepts", acc_cnt - acc0, 640);
        chk("rand_timeout", exp_q.size(), 0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush while frame 0 drains at k=5 and frame 1 has 10 samples
        for (int n = 0; n < 32; n++) cycle(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        for (int n = 0; n < 10; n++) cycle(1'b1, rnd(), rnd(), n >= 5, 1'b0);
        cycle(1'b1, rnd(), rnd(), 1'b1, 1'b1);
        chk("fl_idx_at_flush", out_idx, 5);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("fl_out_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        for (int n = 0; n < 32; n++) cycle(1'b1, rnd(), rnd(), 1'b1, 1'b0);
        drain_all(100);

        // Asynchronous reset mid-drain at k=17
        for (int n = 0; n < 32; n++) cycle(1'b1, rnd(), rnd(), 1'b0, 1'b0);
        c = 0;
        while (exp_q.size() > 15 && c < 40) begin
            cycle(1'b0, '0, '0, 1'b1, 1'b0);
            c++;
        end
        cycle(1'b0, '0, '0, 1'b0, 1'b0);
        chk("rs_pre_idx", out_idx, 17);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rs_out_valid", out_valid, 0);
        chk("rs_out_idx", out_idx, 0);
        chk("rs_in_ready", in_ready, 0);
        chk("rs_out_last", out_last, 0);
        exp_q.delete();
        part_n = 0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("rs_release_in_ready", in_ready, 1);
        chk("rs_release_out_valid", out_valid, 0);
        for (int n = 0; n < 32; n++) cycle(1'b1, rnd(), rnd(), 1'b1, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 1'b0);
        chk("rs_first_idx", out_idx, 0);
        drain_all(100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
